nibble_packer: RTL and testbench

- Reverse direction of the nibble selector path: the selector extracts 4 nibbles from two 32-bit words; this block accepts 4 nibble lanes per beat and scatters them into two 32-bit assembly words, A and B.
- Each lane carries a word select bit (SEL) and a nibble position (sel_pos).
- A word is emitted on its own valid/ready output port when all 8 nibble slots are filled, or when FLUSH is asserted.
- Sits downstream of the nibble-producing datapath and rebuilds words for the register/bus side.

---
 rtl/nibble_packer.sv | 151 +++++++++++++++
 tb/tb_nibble_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - scatters nibble lanes into two 32-bit words A/B with per-word valid/ready (optional ERR via NIBBLE_PACKER_COLLISION_EN)
module nibble_packer #(
  parameter int LANES        = 4,
  parameter int NIB_PER_WORD = 8,
  parameter int POS_W        = 3
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [LANES*4-1:0]        NIBBLE_IN,
  input  logic [LANES*POS_W-1:0]    sel_pos,
  input  logic [LANES-1:0]          SEL,
  input  logic                      FLUSH,
  output logic                      OUT_A_VALID,
  input  logic                      OUT_A_READY,
  output logic [4*NIB_PER_WORD-1:0] DATA_A,
  output logic                      OUT_B_VALID,
  input  logic                      OUT_B_READY,
  output logic [4*NIB_PER_WORD-1:0] DATA_B
`ifdef NIBBLE_PACKER_COLLISION_EN
  ,
  output logic                      ERR
`endif
);

  localparam int WW = 4 * NIB_PER_WORD;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} word_state_t;

  word_state_t             state_a, state_b, state_a_n, state_b_n;
  logic [WW-1:0]           buf_a, buf_b, buf_a_n, buf_b_n;
  logic [NIB_PER_WORD-1:0] mask_a, mask_b, mask_a_n, mask_b_n;
  logic [WW-1:0]           wr_a, wr_b;
  logic [NIB_PER_WORD-1:0] wm_a, wm_b;
  logic                    accept, flush_go, hit;

  assign IN_READY    = (state_a == FILL) && (state_b == FILL);
  assign accept      = IN_VALID && IN_READY;
  assign flush_go    = FLUSH && IN_READY;
  assign OUT_A_VALID = (state_a == HOLD);
  assign OUT_B_VALID = (state_b == HOLD);
  assign DATA_A      = buf_a;
  assign DATA_B      = buf_b;

  // Merge the accepted beat into both words; later lanes overwrite earlier ones, and a running mask flags any rewrite.
  always_comb begin : merge
    logic [POS_W-1:0] pos;
    logic [3:0]       nib;
    wr_a = buf_a;
    wr_b = buf_b;
    wm_a = mask_a;
    wm_b = mask_b;
    hit  = 1'b0;
    pos  = '0;
    nib  = '0;
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        pos = sel_pos[POS_W*i +: POS_W];
        nib = NIBBLE_IN[4*i +: 4];
        if (SEL[i]) begin
          hit = hit | wm_b[pos];
          wr_b[{pos, 2'b00} +: 4] = nib;
          wm_b[pos] = 1'b1;
        end else begin
          hit = hit | wm_a[pos];
          wr_a[{pos, 2'b00} +: 4] = nib;
          wm_a[pos] = 1'b1;
        end
      end
    end
  end

  // Per-word FILL/HOLD next state: complete on full mask, flush on any filled slot, clear when drained.
  always_comb begin
    state_a_n = state_a;
    buf_a_n   = buf_a;
    mask_a_n  = mask_a;
    state_b_n = state_b;
    buf_b_n   = buf_b;
    mask_b_n  = mask_b;
    case (state_a)
      FILL: begin
        if (IN_READY) begin
          buf_a_n  = wr_a;
          mask_a_n = wm_a;
          if ((accept && (&wm_a)) || (flush_go && (|wm_a))) state_a_n = HOLD;
        end
      end
      HOLD: begin
        if (OUT_A_READY) begin
          state_a_n = FILL;
          buf_a_n   = '0;
          mask_a_n  = '0;
        end
      end
      default: state_a_n = FILL;
    endcase
    case (state_b)
      FILL: begin
        if (IN_READY) begin
          buf_b_n  = wr_b;
          mask_b_n = wm_b;
          if ((accept && (&wm_b)) || (flush_go && (|wm_b))) state_b_n = HOLD;
        end
      end
      HOLD: begin
        if (OUT_B_READY) begin
          state_b_n = FILL;
          buf_b_n   = '0;
          mask_b_n  = '0;
        end
      end
      default: state_b_n = FILL;
    endcase
  end

  // State, buffer and mask registers with synchronous reset discarding any partial or pending words.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_a <= FILL;
      state_b <= FILL;
      buf_a   <= '0;
      buf_b   <= '0;
      mask_a  <= '0;
      mask_b  <= '0;
    end else begin
      state_a <= state_a_n;
      state_b <= state_b_n;
      buf_a   <= buf_a_n;
      buf_b   <= buf_b_n;
      mask_a  <= mask_a_n;
      mask_b  <= mask_b_n;
    end
  end

`ifdef NIBBLE_PACKER_COLLISION_EN
  logic err_q;
  assign ERR = err_q;

  // Sticky collision flag: duplicate slot within a beat or rewrite of a filled slot.
  always_ff @(posedge CLK) begin
    if (RESET) err_q <= 1'b0;
    else       err_q <= err_q | hit;
  end
`else
  logic unused_hit;
  assign unused_hit = hit;
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - randomized and directed bench for nibble_packer against a slot-array reference model
module tb_nibble_packer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] NIBBLE_IN = '0;
  logic [11:0] sel_pos = '0;
  logic [3:0]  SEL = '0;
  logic        FLUSH = 1'b0;
  logic        OUT_A_VALID, OUT_B_VALID;
  logic        OUT_A_READY = 1'b0, OUT_B_READY = 1'b0;
  logic [31:0] DATA_A, DATA_B;
`ifdef NIBBLE_PACKER_COLLISION_EN
  logic        ERR;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: per word, 8 nibble slots with a filled flag, plus completion and sticky error flags.
  logic [3:0] m_nib [2][8];
  bit         m_fil [2][8];
  bit         m_hold[2];
  bit         m_err;

  nibble_packer dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .NIBBLE_IN(NIBBLE_IN), .sel_pos(sel_pos), .SEL(SEL), .FLUSH(FLUSH),
    .OUT_A_VALID(OUT_A_VALID), .OUT_A_READY(OUT_A_READY), .DATA_A(DATA_A),
    .OUT_B_VALID(OUT_B_VALID), .OUT_B_READY(OUT_B_READY), .DATA_B(DATA_B)
`ifdef NIBBLE_PACKER_COLLISION_EN
    , .ERR(ERR)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int w);
    logic [31:0] r = 32'h0;
    for (int k = 0; k < 8; k++) r = r + (32'(m_nib[w][k]) << (4 * k));
    return r;
  endfunction

  task automatic clear_word(input int w);
    for (int k = 0; k < 8; k++) begin
      m_nib[w][k] = 4'h0;
      m_fil[w][k] = 1'b0;
    end
    m_hold[w] = 1'b0;
  endtask

  // Advance one clock: update the model from the driven inputs, then sample the DUT 1 time unit after the edge.
  task automatic step();
    bit rdy, full, any, was_reset;
    bit taken[2][8];
    int w, p;
    rdy = !m_hold[0] && !m_hold[1];
    was_reset = RESET;
    if (RESET) begin
      clear_word(0);
      clear_word(1);
      m_err = 1'b0;
    end else if (rdy) begin
      if (IN_VALID) begin
        for (int a = 0; a < 2; a++) for (int b = 0; b < 8; b++) taken[a][b] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          w = int'(SEL[i]);
          p = int'(sel_pos[3*i +: 3]);
          if (taken[w][p] || m_fil[w][p]) m_err = 1'b1;
          taken[w][p] = 1'b1;
          m_nib[w][p] = NIBBLE_IN[4*i +: 4];
          m_fil[w][p] = 1'b1;
        end
      end
      for (int v = 0; v < 2; v++) begin
        full = 1'b1;
        any  = 1'b0;
        for (int k = 0; k < 8; k++) begin
          full = full & m_fil[v][k];
          any  = any | m_fil[v][k];
        end
        if ((IN_VALID && full) || (FLUSH && any)) m_hold[v] = 1'b1;
      end
    end else begin
      if (m_hold[0] && OUT_A_READY) clear_word(0);
      if (m_hold[1] && OUT_B_READY) clear_word(1);
    end
    @(posedge CLK);
    #1;
    check("in_ready", 32'(IN_READY), 32'(!m_hold[0] && !m_hold[1]));
    check("out_a_valid", 32'(OUT_A_VALID), 32'(m_hold[0]));
    check("out_b_valid", 32'(OUT_B_VALID), 32'(m_hold[1]));
    if (was_reset || m_hold[0]) check("data_a", DATA_A, word_of(0));
    if (was_reset || m_hold[1]) check("data_b", DATA_B, word_of(1));
`ifdef NIBBLE_PACKER_COLLISION_EN
    check("err", 32'(ERR), 32'(m_err));
`endif
  endtask

  task automatic drive(input logic v, input logic [15:0] nibs, input logic [11:0] poss,
                       input logic [3:0] sel, input logic f);
    IN_VALID  = v;
    NIBBLE_IN = nibs;
    sel_pos   = poss;
    SEL       = sel;
    FLUSH     = f;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 12'h0, 4'h0, 1'b0);
  endtask

  localparam logic [11:0] POS_0123 = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [11:0] POS_4567 = {3'd7, 3'd6, 3'd5, 3'd4};

  logic [31:0] held_a;

  initial begin
    clear_word(0);
    clear_word(1);
    m_err = 1'b0;

    // Reset and idle
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    step();
    check("reset_data_a", DATA_A, 32'h0);
    check("reset_data_b", DATA_B, 32'h0);
    check("reset_in_ready", 32'(IN_READY), 32'h1);

    // Full assembly of B
    drive(1'b1, 16'hABCD, POS_0123, 4'b1111, 1'b0);
    step();
    check("b_not_yet_valid", 32'(OUT_B_VALID), 32'h0);
    drive(1'b1, 16'h0000, POS_4567, 4'b1111, 1'b0);
    step();
    idle();
    check("b_full_data", DATA_B, 32'h0000ABCD);
    check("b_full_valid", 32'(OUT_B_VALID), 32'h1);
    check("b_full_a_quiet", 32'(OUT_A_VALID), 32'h0);
    step();
    check("b_hold_ready_low", 32'(IN_READY), 32'h0);
    OUT_B_READY = 1'b1;
    step();
    OUT_B_READY = 1'b0;
    step();
    check("b_drained_ready", 32'(IN_READY), 32'h1);

    // Flush a partial A with a lane collision on slot 2
    drive(1'b1, 16'h5FFF, {3'd2, 3'd2, 3'd1, 3'd0}, 4'b0000, 1'b1);
    step();
    idle();
    check("flush_a_data", DATA_A, 32'h000005FF);
    check("flush_a_valid", 32'(OUT_A_VALID), 32'h1);
    check("flush_b_quiet", 32'(OUT_B_VALID), 32'h0);
`ifdef NIBBLE_PACKER_COLLISION_EN
    check("flush_err", 32'(ERR), 32'h1);
`endif

    // Backpressure on A: beats and flush are ignored while A holds
    held_a = DATA_A;
    drive(1'b1, 16'h1234, POS_4567, 4'b1010, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_data_stable", DATA_A, held_a);
      check("bp_ready_low", 32'(IN_READY), 32'h0);
      check("bp_b_quiet", 32'(OUT_B_VALID), 32'h0);
    end
    idle();
    OUT_A_READY = 1'b1;
    step();
    OUT_A_READY = 1'b0;

    // Simultaneous completion of A and B, then drain B before A
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 16'h7777, {3'(2*b+1), 3'(2*b), 3'(2*b+1), 3'(2*b)}, 4'b0011, 1'b0);
      step();
    end
    idle();
    check("sim_a_valid", 32'(OUT_A_VALID), 32'h1);
    check("sim_b_valid", 32'(OUT_B_VALID), 32'h1);
    check("sim_a_data", DATA_A, 32'h77777777);
    check("sim_b_data", DATA_B, 32'h77777777);
    OUT_B_READY = 1'b1;
    step();
    OUT_B_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("sim_wait_ready_low", 32'(IN_READY), 32'h0);
    end
    OUT_A_READY = 1'b1;
    step();
    OUT_A_READY = 1'b0;
    check("sim_after_a_ready", 32'(IN_READY), 32'h1);

    // Reset mid-fill leaves no stale nibbles
    drive(1'b1, 16'h4321, POS_0123, 4'b0000, 1'b0);
    step();
    idle();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("midreset_a_quiet", 32'(OUT_A_VALID), 32'h0);
    drive(1'b1, 16'h9999, POS_4567, 4'b0000, 1'b1);
    step();
    idle();
    check("midreset_data", DATA_A, 32'h99990000);
    OUT_A_READY = 1'b1;
    step();
    OUT_A_READY = 1'b0;

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      RESET       = ($urandom_range(0, 99) == 0);
      IN_VALID    = ($urandom_range(0, 3) != 0);
      NIBBLE_IN   = 16'($urandom);
      sel_pos     = 12'($urandom);
      SEL         = 4'($urandom_range(0, 15));
      FLUSH       = ($urandom_range(0, 5) == 0);
      OUT_A_READY = ($urandom_range(0, 1) == 1);
      OUT_B_READY = ($urandom_range(0, 1) == 1);
      step();
    end
    RESET = 1'b0;
    idle();
    OUT_A_READY = 1'b1;
    OUT_B_READY = 1'b1;
    step();
    step();
    check("final_ready", 32'(IN_READY), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
